// File: rtl/jtag_tap_ctrl_if.sv
// Chain-side bundle of the JTAG TAP controller: the serial input feed,
// enable strobes and shift levels toward the IR/DR cells, and the chain outputs.
interface jtag_tap_ctrl_if;
    logic tdi_s;
    logic tdo_ir;
    logic tdo_dr;
    logic shift_ir;
    logic clk_ir;
    logic update_ir;
    logic shift_dr;
    logic clk_dr;
    logic update_dr;
    logic tlr;

    modport master (
        output tdi_s, shift_ir, clk_ir, update_ir,
        output shift_dr, clk_dr, update_dr, tlr,
        input  tdo_ir, tdo_dr
    );

    modport slave (
        input  tdi_s, shift_ir, clk_ir, update_ir,
        input  shift_dr, clk_dr, update_dr, tlr,
        output tdo_ir, tdo_dr
    );
endinterface

// File: rtl/jtag_tap_ctrl.sv
// IEEE 1149.1-style TAP controller, TCK/TMS/TDI oversampled in the ICLK domain.
// Optional macro JTAG_TAP_STATE_PORT_EN exposes tap_state and tck_rise_dbg.
module jtag_tap_ctrl #(
    parameter int SYNC_STAGES = 2
) (
    input  logic       ICLK,
    input  logic       IRSTn,
    input  logic       TCK,
    input  logic       TMS,
    input  logic       TDI,
    output logic       TDO,
    output logic       TDO_OE,
`ifdef JTAG_TAP_STATE_PORT_EN
    output logic [3:0] tap_state,
    output logic       tck_rise_dbg,
`endif
    jtag_tap_ctrl_if.master chain
);

    typedef enum logic [3:0] {
        TLR    = 4'hF, RTI    = 4'hC,
        SEL_DR = 4'h7, CAP_DR = 4'h6, SH_DR  = 4'h2, EX1_DR = 4'h1,
        PAU_DR = 4'h3, EX2_DR = 4'h0, UPD_DR = 4'h5,
        SEL_IR = 4'h4, CAP_IR = 4'hE, SH_IR  = 4'hA, EX1_IR = 4'h9,
        PAU_IR = 4'hB, EX2_IR = 4'h8, UPD_IR = 4'hD
    } tap_state_e;

    logic [SYNC_STAGES-1:0] tck_sync_q;
    logic [SYNC_STAGES-1:0] tms_sync_q;
    logic [SYNC_STAGES-1:0] tdi_sync_q;
    logic                   tck_prev_q;
    tap_state_e             state_q, state_d;
    logic                   tdo_q, tdo_d;
    logic                   tdo_oe_q, tdo_oe_d;

    logic tck_s, tms_s, tck_rise, tck_fall;
    logic in_sh_ir, in_sh_dr;

    // All three pins tap the same stage so TMS/TDI line up with the TCK edge.
    assign tck_s    = tck_sync_q[SYNC_STAGES-1];
    assign tms_s    = tms_sync_q[SYNC_STAGES-1];
    assign tck_rise = tck_s & ~tck_prev_q;
    assign tck_fall = ~tck_s & tck_prev_q;
    assign in_sh_ir = (state_q == SH_IR);
    assign in_sh_dr = (state_q == SH_DR);

    always_ff @(posedge ICLK or negedge IRSTn) begin
        if (!IRSTn) begin
            tck_sync_q <= '0;
            tms_sync_q <= '0;
            tdi_sync_q <= '0;
            tck_prev_q <= 1'b0;
        end else begin
            tck_sync_q <= {tck_sync_q[SYNC_STAGES-2:0], TCK};
            tms_sync_q <= {tms_sync_q[SYNC_STAGES-2:0], TMS};
            tdi_sync_q <= {tdi_sync_q[SYNC_STAGES-2:0], TDI};
            tck_prev_q <= tck_s;
        end
    end

    always_ff @(posedge ICLK or negedge IRSTn) begin
        if (!IRSTn) begin
            state_q  <= TLR;
            tdo_q    <= 1'b1;
            tdo_oe_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            tdo_q    <= tdo_d;
            tdo_oe_q <= tdo_oe_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (tck_rise) begin
            case (state_q)
                TLR:     state_d = tms_s ? TLR    : RTI;
                RTI:     state_d = tms_s ? SEL_DR : RTI;
                SEL_DR:  state_d = tms_s ? SEL_IR : CAP_DR;
                CAP_DR:  state_d = tms_s ? EX1_DR : SH_DR;
                SH_DR:   state_d = tms_s ? EX1_DR : SH_DR;
                EX1_DR:  state_d = tms_s ? UPD_DR : PAU_DR;
                PAU_DR:  state_d = tms_s ? EX2_DR : PAU_DR;
                EX2_DR:  state_d = tms_s ? UPD_DR : SH_DR;
                UPD_DR:  state_d = tms_s ? SEL_DR : RTI;
                SEL_IR:  state_d = tms_s ? TLR    : CAP_IR;
                CAP_IR:  state_d = tms_s ? EX1_IR : SH_IR;
                SH_IR:   state_d = tms_s ? EX1_IR : SH_IR;
                EX1_IR:  state_d = tms_s ? UPD_IR : PAU_IR;
                PAU_IR:  state_d = tms_s ? EX2_IR : PAU_IR;
                EX2_IR:  state_d = tms_s ? UPD_IR : SH_IR;
                UPD_IR:  state_d = tms_s ? SEL_DR : RTI;
                default: state_d = TLR;
            endcase
        end
    end

    always_comb begin
        chain.tdi_s     = tdi_sync_q[SYNC_STAGES-1];
        chain.shift_ir  = in_sh_ir;
        chain.shift_dr  = in_sh_dr;
        chain.clk_ir    = tck_rise & (in_sh_ir | (state_q == CAP_IR));
        chain.clk_dr    = tck_rise & (in_sh_dr | (state_q == CAP_DR));
        chain.update_ir = tck_fall & (state_q == UPD_IR);
        chain.update_dr = tck_fall & (state_q == UPD_DR);
        chain.tlr       = (state_q == TLR);
        tdo_d           = tdo_q;
        tdo_oe_d        = tdo_oe_q;
        // TDO changes on the falling TCK, half a period before the probe samples.
        if (tck_fall) begin
            tdo_oe_d = in_sh_ir | in_sh_dr;
            if (in_sh_ir)      tdo_d = chain.tdo_ir;
            else if (in_sh_dr) tdo_d = chain.tdo_dr;
        end
    end

    assign TDO    = tdo_q;
    assign TDO_OE = tdo_oe_q;

`ifdef JTAG_TAP_STATE_PORT_EN
    assign tap_state    = state_q;
    assign tck_rise_dbg = tck_rise;
`endif

endmodule

// File: doc/jtag_tap_ctrl.md
Name: jtag_tap_ctrl

Overview:
- IEEE 1149.1-style TAP controller for the on-chip JTAG debug path.
- Samples the external TCK/TMS/TDI pins in the ICLK domain and runs the 16-state TAP FSM.
- Generates the one-ICLK-cycle enable strobes (clk_ir/update_ir, clk_dr/update_dr) and shift level selects that sequence the IR and DR cell chains.
- Muxes the chain serial outputs back onto TDO.

Parameters:
- SYNC_STAGES, 2, number of synchronizer flops on TCK/TMS/TDI. Legal values: 2 or 3.

Ports:
- ICLK  in  1  system clock. Must run at ≥4x TCK.
- IRSTn  in  1  asynchronous active-low reset.
- TCK  in  1  raw JTAG clock pin, asynchronous to ICLK.
- TMS  in  1  raw JTAG mode select pin.
- TDI  in  1  raw JTAG data in pin.
- tdi_s  out  1  synchronized TDI, fed to the s_data_in of the first chain cell.
- tdo_ir  in  1  serial out of the last IR cell.
- tdo_dr  in  1  serial out of the selected DR chain.
- TDO  out  1  registered test data out.
- TDO_OE  out  1  TDO output enable.
- shift_ir  out  1  level, high while the state is SHIFT_IR.
- clk_ir  out  1  IR capture/shift enable strobe.
- update_ir  out  1  IR update strobe.
- shift_dr  out  1  level, high while the state is SHIFT_DR.
- clk_dr  out  1  DR capture/shift enable strobe.
- update_dr  out  1  DR update strobe.
- tlr  out  1  high while the state is TEST_LOGIC_RESET.

Behaviour:
- Reset: IRSTn low asynchronously sets the following.
  - state=TLR, all synchronizer flops=0.
  - TDO=1, TDO_OE=0, tlr=1.
  - All strobes and shift levels =0.
- Synchronizer: TCK, TMS and TDI each pass through SYNC_STAGES flops. A further flop holds the previous synchronized TCK.
  - tck_rise = sync_tck & ~prev_tck.
  - tck_fall = ~sync_tck & prev_tck.
  - Each edge strobe is high for exactly one ICLK cycle per TCK edge.
  - TMS and TDI are taken from the same synchronizer stage as TCK.
- State encoding (4 bit):
  - TLR=F, RTI=C, SEL_DR=7, CAP_DR=6, SH_DR=2, EX1_DR=1, PAU_DR=3, EX2_DR=0, UPD_DR=5.
  - SEL_IR=4, CAP_IR=E, SH_IR=A, EX1_IR=9, PAU_IR=B, EX2_IR=8, UPD_IR=D.
- Transitions: state advances only on ICLK cycles with tck_rise, using sync TMS. Each line below gives the next state for TMS=0 / TMS=1.
  - TLR: RTI / TLR
  - RTI: RTI / SEL_DR
  - SEL_DR: CAP_DR / SEL_IR
  - CAP_DR: SH_DR / EX1_DR
  - SH_DR: SH_DR / EX1_DR
  - EX1_DR: PAU_DR / UPD_DR
  - PAU_DR: PAU_DR / EX2_DR
  - EX2_DR: SH_DR / UPD_DR
  - UPD_DR: RTI / SEL_DR
  - The IR branch is symmetric to the DR branch.
  - SEL_IR: CAP_IR / TLR
- Five consecutive tck_rise with TMS=1 reach TLR from any state.
- Strobes, all combinational from registered state and edge flops:
  - clk_ir = tck_rise & (state==CAP_IR | state==SH_IR). The cell samples while the FSM is still in the current state.
  - shift_ir = (state==SH_IR). Low in CAP_IR, so the cell parallel-captures there.
  - update_ir = tck_fall & (state==UPD_IR). Exactly one pulse per UPD_IR visit.
  - The DR strobes (clk_dr, shift_dr, update_dr) are identical with the DR states.
- TDO:
  - On tck_fall: TDO<=tdo_ir if state==SH_IR, else TDO<=tdo_dr if state==SH_DR.
  - In any other state on tck_fall: TDO holds its value.
  - TDO_OE <= (state==SH_IR | state==SH_DR), updated on tck_fall.
- Simultaneous events: tck_rise and tck_fall can never coincide. IRSTn dominates everything.
- Reset mid-shift: the FSM returns to TLR and no update strobe is issued. Chain contents are left to the cells.
- Latency: a TCK pin edge reaches its strobe SYNC_STAGES to SYNC_STAGES+1 ICLK cycles later.

Optional Feature:
- Macro: JTAG_TAP_STATE_PORT_EN.
- When defined: adds output port tap_state[3:0], driven directly from the state register (encoding above, reset value F), and output tck_rise_dbg (the tck_rise strobe).
- When undefined: neither port exists, and behaviour is otherwise identical.

Test Plan:
- Reset:
  - Stimulus: assert IRSTn=0 mid-SH_DR, release, toggle TCK with TMS=0 once.
  - Required: tlr=1 during reset, TDO_OE=0, no update_dr pulse; after the release and the single TCK, state=RTI and tlr=0.
- TMS reset:
  - Stimulus: from SH_IR, apply 5 TCK with TMS=1.
  - Required: state reaches TLR after the 5th rise, with exactly one update_ir pulse (passing through UPD_IR).
- IR load:
  - Stimulus: TLR→RTI→SEL_DR→SEL_IR→CAP_IR, then shift 4 bits of 0b1010 in SH_IR, exit via EX1_IR→UPD_IR.
  - Required: clk_ir pulses 5 times (1 capture + 4 shift); shift_ir=0 on the capture pulse and 1 on the shift pulses; exactly one update_ir pulse on the falling TCK in UPD_IR.
- DR pause path:
  - Stimulus: CAP_DR→SH_DR(2 bits)→EX1_DR→PAU_DR(3 TCK)→EX2_DR→SH_DR(1 bit)→EX1_DR→UPD_DR.
  - Required: clk_dr pulses 4 times, none while in PAU_DR; one update_dr pulse.
- TDO mux:
  - Stimulus: tdo_dr=1 and tdo_ir=0 during SH_DR.
  - Required: TDO=1 and TDO_OE=1 after the falling TCK; after EX1_DR, TDO_OE=0 and TDO holds its value.
- Edge strobes:
  - Stimulus: TCK period = 8 ICLK.
  - Required: every tck_rise and tck_fall is exactly 1 ICLK wide, and clk_* never asserts in two consecutive ICLK cycles.
